// File: rtl/test_detector_pkg.sv
// test_detector_pkg: shared constants, state encoding and helpers for the test detector writer/reader pair
package test_detector_pkg;
  localparam int DATA_WIDTH  = 66;
  localparam int TEST_BIT_HI = 65;
  localparam int TEST_LO_MSB = 15;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;
  function automatic logic [7:0] pulse_len(input logic [7:0] w);
    return (w == 8'd0) ? 8'd1 : w;
  endfunction
  function automatic logic [1:0] test_flags(input logic [DATA_WIDTH-1:0] d);
    return {d[TEST_BIT_HI], |d[TEST_LO_MSB:0]};
  endfunction
endpackage

// File: rtl/test_detector_downcounter.sv
// test_detector_downcounter: loadable down-counter that flags completion at value 1
module test_detector_downcounter #(
  parameter int CNTR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  load,
  input  logic                  en,
  input  logic [CNTR_WIDTH-1:0] value,
  output logic                  last
);
  import test_detector_pkg::*;
  localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);
  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  // load wins over counting; the counter parks at 1 (or 0) so it never wraps
  always_comb cnt_d = load ? value : (en && cnt_q > ONE) ? cnt_q - ONE : cnt_q;
  // counter register
  always_ff @(posedge aclk or posedge areset)
    if (areset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign last = (cnt_q == ONE);
endmodule

// File: rtl/test_detector_writer.sv
// test_detector_writer: programmable burst generator of hit words for reader loopback tests
module test_detector_writer #(
  parameter int DATA_WIDTH = 66,
  parameter int CNTR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [7:0]            width,
  input  logic [CNTR_WIDTH-1:0] gap,
  input  logic [CNTR_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done,
  output logic [CNTR_WIDTH-1:0] pulses
);
  import test_detector_pkg::*;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, pat_q, pat_d;
  logic [7:0]            wid_q, wid_d;
  logic [CNTR_WIDTH-1:0] gap_q, gap_d, num_q, num_d, pulses_q, pulses_d, w_val;
  logic                  done_q, done_d, w_load, g_load, w_last, g_last;

  test_detector_downcounter #(.CNTR_WIDTH(CNTR_WIDTH)) u_wcnt (
    .aclk(aclk), .areset(areset), .load(w_load), .en(state_q == PULSE),
    .value(w_val), .last(w_last)
  );
  test_detector_downcounter #(.CNTR_WIDTH(CNTR_WIDTH)) u_gcnt (
    .aclk(aclk), .areset(areset), .load(g_load), .en(state_q == GAP),
    .value(gap_q), .last(g_last)
  );

  // next state, next output word and counter loads; config only latched on a start from IDLE
  always_comb begin
    state_d  = state_q;
    dout_d   = '0;
    done_d   = 1'b0;
    pulses_d = pulses_q;
    pat_d    = pat_q;
    wid_d    = wid_q;
    gap_d    = gap_q;
    num_d    = num_q;
    w_load   = 1'b0;
    g_load   = 1'b0;
    w_val    = CNTR_WIDTH'(pulse_len(wid_q));
    if (!enable) state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (trigger) begin
            pat_d    = pattern;
            wid_d    = width;
            gap_d    = gap;
            num_d    = count;
            pulses_d = '0;
            w_load   = 1'b1;
            w_val    = CNTR_WIDTH'(pulse_len(width));
            dout_d   = pattern;
            state_d  = PULSE;
          end
        PULSE:
          if (w_last) begin
            pulses_d = pulses_q + CNTR_WIDTH'(1);
            if (num_q != '0 && pulses_d == num_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (gap_q == '0) begin
              w_load = 1'b1;
              dout_d = pat_q;
            end else begin
              g_load  = 1'b1;
              state_d = GAP;
            end
          end else dout_d = pat_q;
        GAP:
          if (g_last) begin
            w_load  = 1'b1;
            dout_d  = pat_q;
            state_d = PULSE;
          end
        default: state_d = IDLE;
      endcase
  end

  // state, output and latched configuration registers
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      done_q   <= 1'b0;
      pulses_q <= '0;
      pat_q    <= '0;
      wid_q    <= '0;
      gap_q    <= '0;
      num_q    <= '0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      pulses_q <= pulses_d;
      pat_q    <= pat_d;
      wid_q    <= wid_d;
      gap_q    <= gap_d;
      num_q    <= num_d;
    end

  assign dout   = dout_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign pulses = pulses_q;
endmodule

// File: tb/tb_test_detector_writer.sv
// tb_test_detector_writer: directed and randomized burst checks against a queue-based timeline model
module tb_test_detector_writer;
  import test_detector_pkg::*;
  logic        aclk = 1'b0, areset = 1'b1, enable = 1'b0, trigger = 1'b0;
  logic [65:0] pattern = '0, dout;
  logic [7:0]  width = '0;
  logic [15:0] gap = '0, count = '0, pulses;
  logic        busy, done;
  int          checks = 0, failures = 0, fl_cnt = 0;
  logic [1:0]  fl_exp = 2'b00;
  logic [65:0] md[$];
  bit          mb[$], mdn[$];
  int          mp[$];

  test_detector_writer #(.DATA_WIDTH(66), .CNTR_WIDTH(16)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .trigger(trigger),
    .pattern(pattern), .width(width), .gap(gap), .count(count),
    .dout(dout), .busy(busy), .done(done), .pulses(pulses)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input int t, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic push(input logic [65:0] d, input bit b, input bit dn, input int p);
    md.push_back(d);
    mb.push_back(b);
    mdn.push_back(dn);
    mp.push_back(p);
  endtask

  // expected per-cycle timeline: cycle 0 is the cycle right after the starting edge
  task automatic build(input logic [65:0] pat, input int w, input int g, input int c, input int len);
    int we, p;
    we = (w == 0) ? 1 : w;
    p = 0;
    md.delete(); mb.delete(); mdn.delete(); mp.delete();
    while (md.size() < len && (c == 0 || p < c)) begin
      repeat (we) push(pat, 1'b1, 1'b0, p);
      p++;
      if (c == 0 || p < c) repeat (g) push('0, 1'b1, 1'b0, p);
    end
    if (c != 0) push('0, 1'b0, 1'b1, p);
    while (md.size() < len) push('0, 1'b0, 1'b0, p);
  endtask

  task automatic run(input logic [65:0] pat, input int w, input int g, input int c,
                     input int len, input int abort_at, input bit rnd);
    int frozen;
    bit aborted;
    frozen = 0;
    aborted = 1'b0;
    fl_cnt = 0;
    build(pat, w, g, c, len);
    pattern = pat; width = 8'(w); gap = 16'(g); count = 16'(c);
    enable = 1'b1; trigger = 1'b1;
    for (int t = 0; t < len; t++) begin
      @(posedge aclk); #1;
      if (aborted) begin
        chk("abort_dout", t, dout, '0);
        chk("abort_busy", t, 66'(busy), 66'(0));
        chk("abort_done", t, 66'(done), 66'(0));
        chk("abort_pulses", t, 66'(pulses), 66'(frozen));
      end else begin
        chk("dout", t, dout, md[t]);
        chk("busy", t, 66'(busy), 66'(mb[t]));
        chk("done", t, 66'(done), 66'(mdn[t]));
        chk("pulses", t, 66'(pulses), 66'(mp[t]));
      end
      if (test_flags(dout) === fl_exp) fl_cnt++;
      if (t == abort_at) begin
        enable = 1'b0;
        aborted = 1'b1;
        frozen = mp[t];
      end
      trigger = (rnd && !aborted && mb[t]) ? 1'($urandom()) : 1'b0;
      if (rnd && mb[t]) begin
        pattern = {2'($urandom()), $urandom(), $urandom()};
        width = 8'($urandom_range(0, 7));
        gap = 16'($urandom_range(0, 7));
        count = 16'($urandom_range(0, 5));
      end
    end
    enable = 1'b1;
    trigger = 1'b0;
  endtask

  initial begin
    logic [65:0] rp;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_dout", 0, dout, '0);
    chk("rst_busy", 0, 66'(busy), 66'(0));
    chk("rst_done", 0, 66'(done), 66'(0));
    chk("rst_pulses", 0, 66'(pulses), 66'(0));
    areset = 1'b0;
    @(posedge aclk); #1;
    chk("idle_dout", 0, dout, '0);
    run(66'h2_0000_0000_0000_0001, 3, 5, 1, 10, -1, 1'b0);
    rp = {2'($urandom()), $urandom(), $urandom()};
    run(rp, 2, 4, 3, 20, -1, 1'b0);
    run(rp ^ 66'h1, 0, 0, 4, 8, -1, 1'b0);
    run(66'h3_dead_beef_0123_4567, 3, 2, 2, 14, -1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rp = {2'($urandom()), $urandom(), $urandom()};
      run(rp, $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(1, 4), 40, -1, 1'b1);
    end
    rp = {2'($urandom()), $urandom(), $urandom()} | 66'h1;
    run(rp, 1, 1, 0, 30, 20, 1'b0);
    fl_exp = 2'b10;
    run(66'h2_0000_0000_0000_0000, 5, 3, 2, 20, -1, 1'b0);
    chk("flag_bit65_cycles", 0, 66'(fl_cnt), 66'(10));
    fl_exp = 2'b01;
    run(66'h0_0000_0000_0000_0008, 5, 3, 2, 20, -1, 1'b0);
    chk("flag_bit3_cycles", 0, 66'(fl_cnt), 66'(10));
    fl_exp = 2'b00;
    run(rp, 1, 1, 0, 5, -1, 1'b0);
    #3 areset = 1'b1;
    #1;
    chk("areset_dout", 0, dout, '0);
    chk("areset_busy", 0, 66'(busy), 66'(0));
    chk("areset_done", 0, 66'(done), 66'(0));
    chk("areset_pulses", 0, 66'(pulses), 66'(0));
    @(posedge aclk); #1;
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("post_rst_dout", 0, dout, '0);
    chk("post_rst_busy", 0, 66'(busy), 66'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/test_detector_writer.md
Name: test_detector_writer

Overview:
- Stimulus source for the detector readout path: emits programmable 66-bit hit words on dout, to be wired directly to a test_detector_reader din.
- Produces a burst of COUNT pulses; each pulse holds PATTERN for WIDTH cycles, and pulses are separated by GAP idle (all-zero) cycles.
- Used for on-chip loopback testing of the reader's capture window and its test flags (bit 65, OR of bits 15:0).

Parameters:
- DATA_WIDTH, 66, width of pattern/dout.
- CNTR_WIDTH, 16, width of the gap, count and pulse-index counters.

Ports:
- aclk  in  1  system clock, all logic on the rising edge.
- areset  in  1  asynchronous reset, active-high. Clears all state immediately and forces dout=0.
- enable  in  1  level; a low value aborts any burst.
- trigger  in  1  start request, sampled on aclk.
- pattern  in  DATA_WIDTH  hit word emitted during a pulse.
- width  in  8  pulse length in cycles; 0 is treated as 1.
- gap  in  CNTR_WIDTH  zero cycles between pulses; 0 means pulses are back-to-back.
- count  in  CNTR_WIDTH  pulses per burst; 0 means continuous.
- dout  out  DATA_WIDTH  registered output word.
- busy  out  1  high while in PULSE or GAP.
- done  out  1  one-cycle strobe at the end of a counted burst.
- pulses  out  CNTR_WIDTH  number of pulses completed in the current or last burst.

Behaviour:
- Reset values: state=IDLE, dout=0, busy=0, done=0, pulses=0, all latched config=0.
- States:
  - IDLE: dout=0. When trigger=1 and enable=1 at an edge:
    - latch pattern, width, gap and count;
    - clear pulses;
    - load the width counter;
    - go to PULSE, with dout=pattern from that same edge.
    - Latency: trigger sampled at edge k gives dout=pattern visible after edge k.
  - PULSE: dout=latched pattern for exactly max(width,1) cycles. On the last cycle, pulses is incremented. Then:
    - if count≠0 and pulses+1==count: go to IDLE, dout←0, done=1 for one cycle;
    - else if gap==0: reload the width counter and stay in PULSE (dout stays continuously at pattern);
    - else: go to GAP, dout←0.
  - GAP: dout=0 for exactly gap cycles, then go to PULSE and reload the width counter.
- busy is registered and equals (state≠IDLE).
- done is asserted in the same cycle in which dout first returns to 0 after the final pulse.
- Config inputs are ignored while busy; changes take effect only at the next trigger.
- Trigger while busy is ignored; no queuing.
- Simultaneous final-pulse end and trigger: go to IDLE and assert done; that trigger is dropped.
- enable=0 in any state: the next edge gives IDLE, dout=0, done=0, and pulses holds its value.
- pulses wraps modulo 2^CNTR_WIDTH in continuous mode. No other effect.
- areset mid-burst: immediate return to reset values; no done.
- All counters are down-counters. A counter is complete at value 1, so a count of 0 cannot underflow.

Decomposition:
- Shared package test_detector_pkg: DATA_WIDTH=66; TEST_BIT_HI=65; TEST_LO_MSB=15; state enum {IDLE, PULSE, GAP}. The reader and scoreboard share this package.
- One natural sub-module, test_detector_downcounter (loadable, CNTR_WIDTH, load/en/last outputs). It is instantiated twice: for width and for gap.

Test Plan:
- Single pulse: pattern=66'h2_0000_0000_0000_0001, width=3, gap=5, count=1, trigger at edge 10.
  - Required: dout=pattern on cycles 10–12, 0 from 13.
  - done=1 only in cycle 13; pulses=1; busy high on cycles 10–12.
- Burst spacing: width=2, gap=4, count=3.
  - Required: dout pattern on cycles 0–1, 6–7 and 12–13; done at cycle 14; pulses=3.
- Back-to-back and width 0: width=0, gap=0, count=4.
  - Required: dout=pattern for 4 consecutive cycles, then 0; done at cycle 4.
- Abort and reset:
  - count=0, width=1, gap=1 running; drop enable at cycle 20. Required: dout=0 from 21, no done, pulses frozen.
  - Repeat the run and assert areset asynchronously mid-pulse. Required: dout=0 before the next edge.
- Ignored triggers: pulse trigger every cycle during a count=2 burst; also change pattern mid-burst.
  - Required: burst timing unchanged and the latched pattern is used.
  - A trigger coincident with done is dropped.
- Loopback to the reader with cfg=8'd4:
  - pattern bit 65 only gives test=2'b10;
  - pattern bit 3 only gives test=2'b01;
  - the reader holds the flag for 5 cycles per pulse.
